// File: rtl/trng_pkg.sv
// ============================================================================
//  Module      : trng_pkg
//  Description : Shared types and default sizing for the TRNG datapath
//                (entropy core, bit packer, FIFO wrapper).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trng_pkg;

   // Operating states of the entropy post-processing block
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_FAIL   = 2'd3
   } trng_state_t;

   // Default sizing used by all TRNG blocks unless overridden
   localparam int c_WORD_W      = 64;
   localparam int c_WARMUP_BITS = 4096;
   localparam int c_RCT_CUTOFF  = 40;
   localparam int c_DROP_W      = 16;

endpackage : trng_pkg

`default_nettype wire

// File: rtl/trng_rct.sv
// ============================================================================
//  Module      : trng_rct
//  Description : Repetition-count health test. Counts consecutive identical
//                bits; trip pulses combinationally on the bit that brings the
//                run length to CUTOFF. clear drops all history so the next
//                bit starts a fresh run of 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_rct #(
   parameter int CUTOFF = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic data_bit,
   input  logic valid,
   input  logic clear,
   output logic trip
);

   localparam int                 c_CNT_W    = $clog2(CUTOFF + 1);
   localparam logic [c_CNT_W-1:0] c_TRIP_CNT = c_CNT_W'(CUTOFF);

   // A count of zero means "no history": the next bit always starts at 1
   logic [c_CNT_W-1:0] r_count;
   logic               r_prev;
   logic [c_CNT_W-1:0] w_next_count;

   // Run length after the current bit, held at the cutoff instead of wrapping
   always_comb begin
      w_next_count = c_CNT_W'(1);
      if ((r_count != '0) && (data_bit == r_prev)) begin
         if (r_count != c_TRIP_CNT) begin
            w_next_count = r_count + c_CNT_W'(1);
         end else begin
            w_next_count = r_count;
         end
      end
   end

   assign trip = valid && !clear && (w_next_count == c_TRIP_CNT);

   // Run-length history register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_prev  <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
      end else if (valid) begin
         r_count <= w_next_count;
         r_prev  <= data_bit;
      end
   end

endmodule : trng_rct

`default_nettype wire

// File: rtl/trng_bit_packer.sv
// ============================================================================
//  Module      : trng_bit_packer
//  Description : Takes strobed raw entropy bits, runs a repetition-count
//                health test, discards a warm-up prefix and packs accepted
//                bits MSB-first into WORD_W-bit words for the TRNG FIFO.
//                Words completing while fifo_full is high are dropped and
//                counted in a saturating counter.
//                Build option TRNG_VN_DEBIAS_EN inserts a von Neumann
//                corrector between the health test and the packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_bit_packer
   import trng_pkg::*;
#(
   parameter int WORD_W      = c_WORD_W,
   parameter int WARMUP_BITS = c_WARMUP_BITS,
   parameter int RCT_CUTOFF  = c_RCT_CUTOFF,
   parameter int DROP_W      = c_DROP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              raw_bit,
   input  logic              raw_valid,
   input  logic              fifo_full,
   output logic [WORD_W-1:0] data_out,
   output logic              data_valid,
   output logic              health_fail,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              busy
);

   localparam int                 c_BC_W    = $clog2(WORD_W);
   localparam logic [c_BC_W-1:0]  c_BC_LAST = c_BC_W'(WORD_W - 1);
   localparam int                 c_WU_W    = (WARMUP_BITS > 1) ? $clog2(WARMUP_BITS) : 1;
   localparam logic [c_WU_W-1:0]  c_WU_LAST = c_WU_W'(WARMUP_BITS - 1);

   trng_state_t        r_state;
   logic [WORD_W-2:0]  r_shreg;     // partial word; the MSB is only ever needed at completion
   logic [c_BC_W-1:0]  r_bit_cnt;
   logic [c_WU_W-1:0]  r_wu_cnt;

   logic               w_active;
   logic               w_stop;
   logic               w_bit_ok;
   logic               w_run_bit;
   logic               w_rct_clear;
   logic               w_trip;
   logic               w_acc_valid;
   logic               w_acc_bit;
   logic [WORD_W-1:0]  w_word;

   // Bits are only looked at while running; dropping enable wins over a bit
   // arriving in the same cycle, so that bit never reaches the health test.
   assign w_active    = (r_state == ST_WARMUP) || (r_state == ST_RUN);
   assign w_stop      = w_active && !enable;
   assign w_bit_ok    = raw_valid && w_active && enable;
   assign w_run_bit   = w_bit_ok && (r_state == ST_RUN);
   assign w_rct_clear = (r_state == ST_IDLE) || w_stop;

   trng_rct #(
      .CUTOFF (RCT_CUTOFF)
   ) u_rct (
      .clk      (clk),
      .rst      (rst),
      .data_bit (raw_bit),
      .valid    (w_bit_ok),
      .clear    (w_rct_clear),
      .trip     (w_trip)
   );

`ifdef TRNG_VN_DEBIAS_EN
   logic r_pair_have;
   logic r_pair_bit;

   // Von Neumann pairing of RUN bits; the pair restarts whenever RUN is left
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pair_have <= 1'b0;
         r_pair_bit  <= 1'b0;
      end else if ((r_state != ST_RUN) || w_stop) begin
         r_pair_have <= 1'b0;
         r_pair_bit  <= 1'b0;
      end else if (w_run_bit) begin
         r_pair_have <= !r_pair_have;
         if (!r_pair_have) begin
            r_pair_bit <= raw_bit;
         end
      end
   end

   // 01 -> 0, 10 -> 1: the output equals the first bit of an unequal pair
   assign w_acc_valid = w_run_bit && r_pair_have && (r_pair_bit != raw_bit);
   assign w_acc_bit   = r_pair_bit;
`else
   assign w_acc_valid = w_run_bit;
   assign w_acc_bit   = raw_bit;
`endif

   assign w_word = {r_shreg, w_acc_bit};

   // Control FSM with packer, backpressure handling and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_wu_cnt    <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         health_fail <= 1'b0;
         drop_cnt    <= '0;
         busy        <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  r_state <= ST_WARMUP;
                  busy    <= 1'b1;
               end
            end
            ST_WARMUP, ST_RUN: begin
               if (w_stop) begin
                  r_state   <= ST_IDLE;
                  busy      <= 1'b0;
                  r_shreg   <= '0;
                  r_bit_cnt <= '0;
                  r_wu_cnt  <= '0;
               end else if (w_trip) begin
                  // Any word completing on the tripping bit is discarded
                  r_state     <= ST_FAIL;
                  health_fail <= 1'b1;
                  busy        <= 1'b0;
               end else if (r_state == ST_WARMUP) begin
                  if (raw_valid) begin
                     if (r_wu_cnt == c_WU_LAST) begin
                        r_state <= ST_RUN;
                     end else begin
                        r_wu_cnt <= r_wu_cnt + c_WU_W'(1);
                     end
                  end
               end else if (w_acc_valid) begin
                  r_shreg <= w_word[WORD_W-2:0];
                  if (r_bit_cnt == c_BC_LAST) begin
                     r_bit_cnt <= '0;
                     if (fifo_full) begin
                        if (drop_cnt != {DROP_W{1'b1}}) begin
                           drop_cnt <= drop_cnt + DROP_W'(1);
                        end
                     end else begin
                        data_out   <= w_word;
                        data_valid <= 1'b1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + c_BC_W'(1);
                  end
               end
            end
            ST_FAIL: begin
               // Terminal until reset
               busy <= 1'b0;
            end
            default: begin
               r_state <= ST_FAIL;
            end
         endcase
      end
   end

endmodule : trng_bit_packer

`default_nettype wire

// File: tb/tb_trng_bit_packer.sv
// ============================================================================
//  Module      : tb_trng_bit_packer
//  Description : Self-checking bench for trng_bit_packer (WORD_W=64,
//                WARMUP_BITS=8, RCT_CUTOFF=40, DROP_W=2). Expected words are
//                queued as stimulus is driven and popped on each data_valid.
//                Build option TRNG_VN_DEBIAS_EN selects the corrector test.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trng_bit_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        raw_bit = 1'b0;
   logic        raw_valid = 1'b0;
   logic        fifo_full = 1'b0;
   logic [63:0] data_out;
   logic        data_valid;
   logic        health_fail;
   logic [1:0]  drop_cnt;
   logic        busy;

   int          checks = 0;
   int          failures = 0;
   int          n_valid = 0;
   int          exp_valid = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;

   typedef struct {
      logic [63:0] word;
      logic        full;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;

   trng_bit_packer #(
      .WORD_W      (64),
      .WARMUP_BITS (8),
      .RCT_CUTOFF  (40),
      .DROP_W      (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .raw_bit     (raw_bit),
      .raw_valid   (raw_valid),
      .fifo_full   (fifo_full),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .health_fail (health_fail),
      .drop_cnt    (drop_cnt),
      .busy        (busy)
   );

   // Scoreboard: every write strobe must match the oldest queued word
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         n_valid++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid: data_out=%h but no word expected", data_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (data_out !== mon_exp) begin
               failures++;
               $display("FAIL word: data_out=%h expected %h", data_out, mon_exp);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      raw_bit   = b;
      raw_valid = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
   endtask

   // Sends the top n bits of v, MSB first
   task automatic send_bits(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         send_bit(v[63-i]);
      end
   endtask

   task automatic send_word(input logic [63:0] v, input logic expect_out);
      if (expect_out) begin
         exp_q.push_back(v);
         exp_valid++;
      end
      send_bits(v, 64);
   endtask

   task automatic start_run();
      enable = 1'b1;
      tick(1);
      send_bits({8'h96, 56'h0}, 8);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data_out"}, data_out, 64'h0);
      chk({tag, "_data_valid"}, 64'(data_valid), 64'h0);
      chk({tag, "_health_fail"}, 64'(health_fail), 64'h0);
      chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'h0);
      chk({tag, "_busy"}, 64'(busy), 64'h0);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int nv;
      tbl[0] = '{64'hAAAA_AAAA_AAAA_AAAA, 1'b0};
      tbl[1] = '{64'h0123_4567_89AB_CDEF, 1'b0};
      tbl[2] = '{64'hFFFF_FFFF_0000_0000, 1'b0};
      tbl[3] = '{64'h8421_8421_8421_8421, 1'b1};
      tbl[4] = '{64'h0F0F_F0F0_3C3C_C3C3, 1'b0};
      tbl[5] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b1};
      tbl[6] = '{64'h5555_5555_5555_5555, 1'b0};

      #12;
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef TRNG_VN_DEBIAS_EN
      start_run();
      chk("dbg_busy", 64'(busy), 64'h1);
      exp_q.push_back(64'h5555_5555_5555_5555);
      exp_valid++;
      for (int g = 0; g < 31; g++) begin
         send_bits({8'b0110_0011, 56'h0}, 8);
      end
      tick(2);
      chk("dbg_no_word_before_128_pairs", 64'(n_valid), 64'd0);
      send_bits({8'b0110_0011, 56'h0}, 8);
      tick(2);
      chk("dbg_one_word", 64'(n_valid), 64'd1);
      chk("dbg_data_out", data_out, 64'h5555_5555_5555_5555);
      chk("dbg_health", 64'(health_fail), 64'h0);
`else
      // Warm-up then one alternating word
      start_run();
      tick(2);
      chk("warmup_no_valid", 64'(n_valid), 64'd0);
      chk("warmup_busy", 64'(busy), 64'h1);
      send_word(64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
      tick(2);
      chk("first_word_count", 64'(n_valid), 64'd1);
      chk("first_word_data", data_out, 64'hAAAA_AAAA_AAAA_AAAA);

      // Table of words with per-word backpressure
      for (int i = 0; i < 7; i++) begin
         fifo_full = tbl[i].full;
         send_word(tbl[i].word, !tbl[i].full);
      end
      fifo_full = 1'b0;
      tick(2);
      chk("table_drop_cnt", 64'(drop_cnt), 64'd2);
      chk("table_valid_count", 64'(n_valid), 64'(exp_valid));
      chk("table_last_data", data_out, 64'h5555_5555_5555_5555);

      // Health test: runs of 39 never trip
      exp_q.push_back(64'h7FFF_FFFF_FF7F_FFFF);
      exp_valid++;
      send_bit(1'b0);
      repeat (39) send_bit(1'b1);
      send_bit(1'b0);
      repeat (39) send_bit(1'b1);
      tick(2);
      chk("rct_39_no_fail", 64'(health_fail), 64'h0);
      chk("rct_39_word", data_out, 64'h7FFF_FFFF_FF7F_FFFF);

      // 40 zeros trip on the bit that also completes a word
      nv = n_valid;
      send_bits({8'h55, 56'h0}, 8);
      repeat (40) send_bit(1'b0);
      tick(2);
      chk("rct_40_fail", 64'(health_fail), 64'h1);
      chk("rct_fail_busy", 64'(busy), 64'h0);
      chk("rct_trip_word_suppressed", 64'(n_valid), 64'(nv));
      send_word(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
      enable = 1'b0;
      tick(3);
      enable = 1'b1;
      tick(3);
      chk("fail_sticky", 64'(health_fail), 64'h1);
      chk("fail_no_output", 64'(n_valid), 64'(nv));
      chk("fail_busy", 64'(busy), 64'h0);
      enable = 1'b0;
      do_reset();
      chk("reset_clears_fail", 64'(health_fail), 64'h0);

      // Backpressure with a 2-bit saturating drop counter
      start_run();
      nv = n_valid;
      fifo_full = 1'b1;
      send_word(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
      send_word(64'h0123_4567_89AB_CDEF, 1'b0);
      send_word(64'h5555_5555_5555_5555, 1'b0);
      tick(2);
      chk("drop_cnt_3", 64'(drop_cnt), 64'd3);
      send_word(64'h0F0F_F0F0_3C3C_C3C3, 1'b0);
      send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b0);
      tick(2);
      chk("drop_cnt_saturated", 64'(drop_cnt), 64'd3);
      chk("drop_no_valid", 64'(n_valid), 64'(nv));
      chk("drop_data_unchanged", data_out, 64'h0);
      fifo_full = 1'b0;

      // Drop enable mid-word: partial bits must not leak into the next word
      send_bits(64'hFEDC_BA98_7654_3210, 30);
      enable = 1'b0;
      tick(2);
      chk("disable_busy", 64'(busy), 64'h0);
      start_run();
      send_word(64'h0123_4567_89AB_CDEF, 1'b1);
      tick(2);
      chk("reenable_word", data_out, 64'h0123_4567_89AB_CDEF);
      chk("reenable_count", 64'(n_valid), 64'(nv + 1));

      // Asynchronous reset mid-word, away from any clock edge
      send_bits(64'hAAAA_AAAA_AAAA_AAAA, 20);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      enable = 1'b0;
      tick(1);
      start_run();
      send_word(64'hC3C3_3C3C_A5A5_5A5A, 1'b1);
      tick(2);
      chk("fresh_word_after_rst", data_out, 64'hC3C3_3C3C_A5A5_5A5A);
`endif

      tick(2);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("total_valid_count", 64'(n_valid), 64'(exp_valid));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_trng_bit_packer

`default_nettype wire

// File: doc/trng_bit_packer.md
Name: trng_bit_packer

Overview:
- Sits between the ring-oscillator entropy core's raw-bit output and the 64-bit TRNG FIFO.
- Accepts a raw bit stream with per-bit strobe and runs a repetition-count health test on the raw bits.
- Optionally debiases the stream, then packs accepted bits into 64-bit words.
- Emits each word with a one-cycle valid pulse into the FIFO write port; honours FIFO full by dropping and counting.

Parameters:
- WORD_W, 64, output word width (bits packed per word).
- WARMUP_BITS, 4096, raw bits discarded after enable before packing starts.
- RCT_CUTOFF, 40, consecutive identical raw bits that trip the health failure.
- DROP_W, 16, width of the saturating dropped-word counter.

Ports:
- clk  in  1  system clock for the TRNG domain.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  run request; low returns the block to IDLE.
- raw_bit  in  1  raw entropy bit, sampled only when raw_valid=1.
- raw_valid  in  1  one-cycle strobe per raw bit.
- fifo_full  in  1  downstream FIFO full flag.
- data_out  out  WORD_W  packed random word.
- data_valid  out  1  one-cycle write strobe for data_out.
- health_fail  out  1  sticky RCT failure flag.
- drop_cnt  out  DROP_W  words dropped due to fifo_full, saturating.
- busy  out  1  high in WARMUP or RUN.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values: data_out=0, data_valid=0, health_fail=0, drop_cnt=0, busy=0. Internal state: state=IDLE, shift register=0, bit counter=0, RCT counter=0.
- FSM states: IDLE, WARMUP, RUN, FAIL.
  - IDLE -> WARMUP when enable=1.
  - WARMUP -> RUN after WARMUP_BITS raw_valid strobes have been counted.
  - WARMUP or RUN -> IDLE when enable=0. On this transition, clear the partial word, bit counter, warmup counter, RCT history and debias pair.
  - Any state except IDLE -> FAIL when the RCT trips. FAIL is left only by rst; enable has no effect in FAIL.
- RCT:
  - Runs on every raw_valid bit in WARMUP and RUN.
  - Count starts at 1 on the first bit after IDLE. Equal to previous bit: count+1. Different: count=1.
  - When count reaches RCT_CUTOFF, health_fail=1 in the next cycle and the state enters FAIL.
  - A word completing in the same cycle as the trip is not emitted.
- Packing (RUN only):
  - Each accepted bit shifts in as shreg = {shreg[WORD_W-2:0], bit}, so the first accepted bit ends in the MSB.
  - On the WORD_W-th accepted bit, data_out is loaded and data_valid=1 one cycle after the accepting raw_valid cycle. Latency is 1 clk.
  - The bit counter wraps to 0 and the next word starts immediately; no bits are lost at the word boundary.
- Backpressure:
  - fifo_full is sampled in the cycle the word completes.
  - If fifo_full=1: no data_valid, data_out unchanged, drop_cnt+1, saturating at all-ones.
- data_valid is never high on two consecutive cycles unless raw_valid arrives on consecutive cycles with WORD_W=1 (not a supported configuration; WORD_W must be >= 8).
- raw_valid while IDLE or FAIL is ignored.

Optional Feature:
- Macro: TRNG_VN_DEBIAS_EN.
- Defined: von Neumann corrector between the RCT and the packer.
  - Raw bits are paired in arrival order: 01 yields 0, 10 yields 1, 00 and 11 are discarded.
  - The pair register clears on IDLE.
  - Packing uses only corrector outputs, so word rate drops to roughly 1/4 of the raw rate or lower.
- Undefined: every raw bit in RUN is an accepted bit. No pair register is instantiated.

Decomposition:
- Package trng_pkg:
  - state enum type (IDLE/WARMUP/RUN/FAIL).
  - localparam defaults for WORD_W, RCT_CUTOFF, WARMUP_BITS.
  - shared by the entropy core and the FIFO wrapper.
- Sub-module trng_rct:
  - Repetition-count test with inputs bit, valid, clear; output trip.
  - Reusable by a future adaptive-proportion test block.

Test Plan:
- Config: WARMUP_BITS=8, WORD_W=64, debias off. Enable, then 8 raw bits followed by 64 alternating bits starting with 1 -> exactly one data_valid; data_out=64'hAAAA_AAAA_AAAA_AAAA; no valid pulse during warmup.
- Config: RCT_CUTOFF=40. Feed 39 ones, one zero, then 39 ones -> health_fail stays 0. Then feed 40 consecutive zeros -> health_fail=1, state FAIL, no further data_valid; enable toggling does not clear it; rst does.
- Hold fifo_full=1 while 3 words complete -> data_valid never asserts, drop_cnt=3. With DROP_W=2, a 5th dropped word leaves drop_cnt=3 (saturated).
- Drop enable mid-word after 30 bits of RUN, then re-enable -> warmup repeats; the first emitted word contains only bits fed after re-enable.
- With TRNG_VN_DEBIAS_EN: feed pairs 01,10,00,11 repeated 32 times (after warmup) -> first word=64'h5555_5555_5555_5555. It is emitted after 128 pairs.
- Assert rst asynchronously mid-word with no clock edge -> all outputs go to reset values immediately; the next word after restart is fully fresh.
